rv0_idu: RTL and testbench

- Instruction decode unit, directly downstream of the instruction fetch unit.
- Accepts one fetched 32-bit RV32I instruction and its address per handshake, decodes it, and registers the result into a single-entry output stage for the execute unit.
- Handles operand selection, immediate generation, and illegal-instruction detection.
- Drops in-flight work on flush and control transfer.

---
 rtl/rv0_pkg.sv | 49 ++++
 rtl/rv0_idu_if.sv | 45 ++++
 rtl/rv0_idu_imm.sv | 32 +++
 rtl/rv0_idu.sv | 197 +++++++++++++++++++
 tb/tb_rv0_idu.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv0_pkg.sv
// rv0_pkg: shared types for the rv0 decode unit.
//   rv0_dec_op_e  - operation class handed to the execute unit
//   rv0_alu_op_e  - ALU function
//   rv0_imm_fmt_e - immediate format selector for rv0_idu_imm
//   OPC_*         - RV32I base opcodes
//   alu_from_f3   - maps funct3 (+ alternate bit) to an ALU function
`timescale 1ns/1ps
package rv0_pkg;

    typedef enum logic [3:0] {
        OP_NOP, OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_CSR, OP_SYS
    } rv0_dec_op_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } rv0_alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } rv0_imm_fmt_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // alt selects SUB over ADD (funct3 0) and SRA over SRL (funct3 5).
    function automatic rv0_alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_from_f3 = ALU_SLL;
            3'd2:    alu_from_f3 = ALU_SLT;
            3'd3:    alu_from_f3 = ALU_SLTU;
            3'd4:    alu_from_f3 = ALU_XOR;
            3'd5:    alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv0_idu_if.sv
// rv0_idu_if: fetch-side and execute-side handshake bundle of the decode unit.
//   master - the environment (fetch drives insn_*, execute drives dec_ack_i)
//   slave  - the decode unit
`timescale 1ns/1ps
interface rv0_idu_if #(
    parameter int XLEN = 32
);
    import rv0_pkg::*;

    logic [31:0]      insn_i;
    logic [XLEN-1:0]  addr_i;
    logic             insn_rdy_i;
    logic             insn_ack_o;

    logic             dec_rdy_o;
    logic             dec_ack_i;
    logic [XLEN-1:0]  dec_addr_o;
    logic [4:0]       dec_rs1_o;
    logic [4:0]       dec_rs2_o;
    logic [4:0]       dec_rd_o;
    logic [XLEN-1:0]  dec_imm_o;
    rv0_dec_op_e      dec_op_o;
    rv0_alu_op_e      dec_alu_o;
    logic             dec_src_a_o;
    logic             dec_src_b_o;
    logic             dec_we_o;
    logic [1:0]       dec_mem_size_o;
    logic             dec_mem_uns_o;
    logic             dec_illegal_o;

    modport master (
        output insn_i, addr_i, insn_rdy_i, dec_ack_i,
        input  insn_ack_o, dec_rdy_o, dec_addr_o, dec_rs1_o, dec_rs2_o, dec_rd_o,
               dec_imm_o, dec_op_o, dec_alu_o, dec_src_a_o, dec_src_b_o, dec_we_o,
               dec_mem_size_o, dec_mem_uns_o, dec_illegal_o
    );

    modport slave (
        input  insn_i, addr_i, insn_rdy_i, dec_ack_i,
        output insn_ack_o, dec_rdy_o, dec_addr_o, dec_rs1_o, dec_rs2_o, dec_rd_o,
               dec_imm_o, dec_op_o, dec_alu_o, dec_src_a_o, dec_src_b_o, dec_we_o,
               dec_mem_size_o, dec_mem_uns_o, dec_illegal_o
    );

endinterface

// File: rtl/rv0_idu_imm.sv
// rv0_idu_imm: combinational RV32I immediate generator.
//   insn - instruction bits [31:7] (the opcode never contributes)
//   fmt  - immediate format
//   imm  - immediate sign-extended from insn[31] to XLEN
`timescale 1ns/1ps
module rv0_idu_imm
    import rv0_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     insn,
    input  rv0_imm_fmt_e    fmt,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        case (fmt)
            IMM_I:   imm32 = {{21{insn[31]}}, insn[30:20]};
            IMM_S:   imm32 = {{21{insn[31]}}, insn[30:25], insn[11:7]};
            IMM_B:   imm32 = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U:   imm32 = {insn[31:12], 12'b0};
            IMM_J:   imm32 = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast widens by sign extension.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/rv0_idu.sv
// rv0_idu: RV32I instruction decode unit with a single-entry output register.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   idu_flush_i   - drop the held entry and block the current input
//   ct_trans_i    - control transfer taken, same effect as flush
//   bus (slave)   - insn_*/addr_i from fetch, dec_* to execute
// Parameters: XLEN integer/address width, FLEN floating-point width (no FP decode here).
`timescale 1ns/1ps
module rv0_idu
    import rv0_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int FLEN = 32
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     idu_flush_i,
    input  logic     ct_trans_i,
    rv0_idu_if.slave bus
);

    if (XLEN < 32 || (FLEN != 32 && FLEN != 64)) begin : g_param_chk
        $error("rv0_idu: XLEN must be >= 32 and FLEN 32 or 64");
    end

    logic [31:0]     insn_p0;
    logic [6:0]      opc_p0, f7_p0;
    logic [2:0]      f3_p0;
    rv0_dec_op_e     op_p0;
    rv0_alu_op_e     alu_p0;
    rv0_imm_fmt_e    fmt_p0;
    logic [4:0]      rs1_p0, rs2_p0, rd_p0;
    logic            src_a_p0, src_b_p0, uns_p0, ill_p0;
    logic [1:0]      size_p0;
    logic [XLEN-1:0] imm_fmt_p0, imm_p0;

    assign insn_p0 = bus.insn_i;
    assign opc_p0  = insn_p0[6:0];
    assign f3_p0   = insn_p0[14:12];
    assign f7_p0   = insn_p0[31:25];

    rv0_idu_imm #(.XLEN(XLEN)) u_imm (
        .insn (insn_p0[31:7]),
        .fmt  (fmt_p0),
        .imm  (imm_fmt_p0)
    );

    // ---- stage p0: field decode ----
    always_comb begin
        op_p0    = OP_NOP;
        alu_p0   = ALU_ADD;
        fmt_p0   = IMM_NONE;
        rs1_p0   = '0;
        rs2_p0   = '0;
        rd_p0    = '0;
        src_a_p0 = 1'b0;
        src_b_p0 = 1'b0;
        size_p0  = 2'b00;
        uns_p0   = 1'b0;
        ill_p0   = 1'b0;
        if (insn_p0[1:0] != 2'b11) begin
            ill_p0 = 1'b1;
        end else begin
            case (opc_p0)
                OPC_LUI: begin
                    op_p0 = OP_ALU; alu_p0 = ALU_PASSB; fmt_p0 = IMM_U;
                    rd_p0 = insn_p0[11:7]; src_b_p0 = 1'b1;
                end
                OPC_AUIPC: begin
                    op_p0 = OP_ALU; fmt_p0 = IMM_U; rd_p0 = insn_p0[11:7];
                    src_a_p0 = 1'b1; src_b_p0 = 1'b1;
                end
                OPC_JAL: begin
                    op_p0 = OP_JAL; fmt_p0 = IMM_J; rd_p0 = insn_p0[11:7];
                    src_a_p0 = 1'b1; src_b_p0 = 1'b1;
                end
                OPC_JALR: begin
                    ill_p0 = (f3_p0 != 3'd0);
                    op_p0 = OP_JALR; fmt_p0 = IMM_I; src_b_p0 = 1'b1;
                    rs1_p0 = insn_p0[19:15]; rd_p0 = insn_p0[11:7];
                end
                OPC_BRANCH: begin
                    ill_p0 = (f3_p0[2:1] == 2'b01);
                    op_p0 = OP_BRANCH; fmt_p0 = IMM_B;
                    rs1_p0 = insn_p0[19:15]; rs2_p0 = insn_p0[24:20];
                    // EQ/NE compare by subtraction, LT/GE and LTU/GEU by set-less-than.
                    alu_p0 = !f3_p0[2] ? ALU_SUB : (!f3_p0[1] ? ALU_SLT : ALU_SLTU);
                end
                OPC_LOAD: begin
                    ill_p0 = (f3_p0 == 3'd3) || (f3_p0[2:1] == 2'b11);
                    op_p0 = OP_LOAD; fmt_p0 = IMM_I; src_b_p0 = 1'b1;
                    rs1_p0 = insn_p0[19:15]; rd_p0 = insn_p0[11:7];
                    size_p0 = f3_p0[1:0]; uns_p0 = f3_p0[2];
                end
                OPC_STORE: begin
                    ill_p0 = f3_p0[2] || (f3_p0[1:0] == 2'b11);
                    op_p0 = OP_STORE; fmt_p0 = IMM_S; src_b_p0 = 1'b1;
                    rs1_p0 = insn_p0[19:15]; rs2_p0 = insn_p0[24:20];
                    size_p0 = f3_p0[1:0];
                end
                OPC_OP_IMM: begin
                    ill_p0 = ((f3_p0 == 3'd1) && (f7_p0 != 7'h00)) ||
                             ((f3_p0 == 3'd5) && (f7_p0 != 7'h00) && (f7_p0 != 7'h20));
                    op_p0 = OP_ALU; fmt_p0 = IMM_I; src_b_p0 = 1'b1;
                    rs1_p0 = insn_p0[19:15]; rd_p0 = insn_p0[11:7];
                    // funct7 only qualifies the right shift; ADDI has no SUB form.
                    alu_p0 = alu_from_f3(f3_p0, (f3_p0 == 3'd5) && f7_p0[5]);
                end
                OPC_OP: begin
                    ill_p0 = ((f7_p0 != 7'h00) && (f7_p0 != 7'h20)) ||
                             ((f7_p0 == 7'h20) && (f3_p0 != 3'd0) && (f3_p0 != 3'd5));
                    op_p0 = OP_ALU; alu_p0 = alu_from_f3(f3_p0, f7_p0[5]);
                    rs1_p0 = insn_p0[19:15]; rs2_p0 = insn_p0[24:20]; rd_p0 = insn_p0[11:7];
                end
                OPC_MISC_MEM: begin
                    ill_p0 = (f3_p0 != 3'd0);
                end
                OPC_SYSTEM: begin
                    if (f3_p0 == 3'd0) begin
                        ill_p0 = (insn_p0 != 32'h0000_0073) && (insn_p0 != 32'h0010_0073);
                        op_p0 = OP_SYS; fmt_p0 = IMM_I;
                    end else begin
                        ill_p0 = (f3_p0 == 3'd4);
                        op_p0 = OP_CSR; fmt_p0 = IMM_I;
                        rs1_p0 = insn_p0[19:15]; rd_p0 = insn_p0[11:7];
                        alu_p0 = (f3_p0[1:0] == 2'b01) ? ALU_PASSB :
                                 (f3_p0[1:0] == 2'b10) ? ALU_OR : ALU_AND;
                    end
                end
                default: ill_p0 = 1'b1;
            endcase
        end
        // Illegal entries travel as a NOP carrying the raw word.
        if (ill_p0) begin
            op_p0 = OP_NOP; alu_p0 = ALU_ADD; fmt_p0 = IMM_NONE;
            rs1_p0 = '0; rs2_p0 = '0; rd_p0 = '0;
            src_a_p0 = 1'b0; src_b_p0 = 1'b0; size_p0 = 2'b00; uns_p0 = 1'b0;
        end
    end

    assign imm_p0 = ill_p0 ? XLEN'(insn_p0) : imm_fmt_p0;

    logic flush, in_xfer, out_xfer, vld_p1;

    assign flush          = idu_flush_i | ct_trans_i;
    assign bus.insn_ack_o = !flush && (!vld_p1 || bus.dec_ack_i);
    assign in_xfer        = bus.insn_rdy_i && bus.insn_ack_o;
    assign out_xfer       = vld_p1 && bus.dec_ack_i;

    // ---- stage p1: output register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       vld_p1 <= 1'b0;
        else if (flush)    vld_p1 <= 1'b0;
        else if (in_xfer)  vld_p1 <= 1'b1;
        else if (out_xfer) vld_p1 <= 1'b0;
    end

    logic [XLEN-1:0] addr_p1, imm_p1;
    logic [4:0]      rs1_p1, rs2_p1, rd_p1;
    rv0_dec_op_e     op_p1;
    rv0_alu_op_e     alu_p1;
    logic            src_a_p1, src_b_p1, we_p1, uns_p1, ill_p1;
    logic [1:0]      size_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_p1 <= '0; imm_p1 <= '0;
            rs1_p1 <= '0; rs2_p1 <= '0; rd_p1 <= '0;
            op_p1 <= OP_NOP; alu_p1 <= ALU_ADD;
            src_a_p1 <= 1'b0; src_b_p1 <= 1'b0; we_p1 <= 1'b0;
            size_p1 <= 2'b00; uns_p1 <= 1'b0; ill_p1 <= 1'b0;
        end else if (in_xfer) begin
            addr_p1 <= bus.addr_i; imm_p1 <= imm_p0;
            rs1_p1 <= rs1_p0; rs2_p1 <= rs2_p0; rd_p1 <= rd_p0;
            op_p1 <= op_p0; alu_p1 <= alu_p0;
            src_a_p1 <= src_a_p0; src_b_p1 <= src_b_p0;
            // rd is already cleared for non-writing and illegal entries.
            we_p1 <= (rd_p0 != 5'd0);
            size_p1 <= size_p0; uns_p1 <= uns_p0; ill_p1 <= ill_p0;
        end
    end

    assign bus.dec_rdy_o      = vld_p1;
    assign bus.dec_addr_o     = addr_p1;
    assign bus.dec_rs1_o      = rs1_p1;
    assign bus.dec_rs2_o      = rs2_p1;
    assign bus.dec_rd_o       = rd_p1;
    assign bus.dec_imm_o      = imm_p1;
    assign bus.dec_op_o       = op_p1;
    assign bus.dec_alu_o      = alu_p1;
    assign bus.dec_src_a_o    = src_a_p1;
    assign bus.dec_src_b_o    = src_b_p1;
    assign bus.dec_we_o       = we_p1;
    assign bus.dec_mem_size_o = size_p1;
    assign bus.dec_mem_uns_o  = uns_p1;
    assign bus.dec_illegal_o  = ill_p1;

endmodule

// File: tb/tb_rv0_idu.sv
// tb_rv0_idu: scoreboard bench for rv0_idu. Accepted instructions push a
// reference decode into a queue; a monitor pops and compares each entry the
// execute side accepts, and checks held entries stay stable.
`timescale 1ns/1ps
module tb_rv0_idu;
    import rv0_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  op, alu;
        logic        sa, sb, we;
        logic [1:0]  sz;
        logic        uns, ill;
    } dec_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_r = 1'b0;
    logic ct_r = 1'b0;
    always #5 clk = ~clk;

    rv0_idu_if #(.XLEN(32)) bus ();

    rv0_idu #(.XLEN(32), .FLEN(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .idu_flush_i (flush_r),
        .ct_trans_i  (ct_r),
        .bus         (bus.slave)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    dec_t exp_q[$];
    logic last_acc;

    rv0_alu_op_e base_alu [0:7] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                    ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference decode built from the ISA rules with plain arithmetic.
    function automatic dec_t model(input logic [31:0] w, input logic [31:0] a);
        dec_t d;
        logic signed [31:0] sw;
        logic [31:0] ii;
        int f3, f7;
        bit ok;
        sw = w;
        ii = sw >>> 20;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        d = '0;
        d.addr = a;
        d.op = OP_NOP;
        d.alu = ALU_ADD;
        ok = 1'b1;
        if (w[1:0] != 2'b11) ok = 1'b0;
        else case (w[6:0])
            7'h37: begin d.op = OP_ALU; d.alu = ALU_PASSB; d.sb = 1; d.rd = w[11:7];
                         d.imm = w & 32'hFFFF_F000; end
            7'h17: begin d.op = OP_ALU; d.sa = 1; d.sb = 1; d.rd = w[11:7];
                         d.imm = w & 32'hFFFF_F000; end
            7'h6F: begin d.op = OP_JAL; d.sa = 1; d.sb = 1; d.rd = w[11:7];
                         d.imm = (w[31] ? 32'hFFF0_0000 : 32'h0) | (w & 32'h000F_F000)
                               | (32'(w[20]) << 11) | (32'(w[30:21]) << 1); end
            7'h67: begin ok = (f3 == 0); d.op = OP_JALR; d.sb = 1; d.rs1 = w[19:15];
                         d.rd = w[11:7]; d.imm = ii; end
            7'h63: begin ok = (f3 != 2 && f3 != 3); d.op = OP_BRANCH;
                         d.rs1 = w[19:15]; d.rs2 = w[24:20];
                         d.alu = (f3 < 4) ? ALU_SUB : ((f3 < 6) ? ALU_SLT : ALU_SLTU);
                         d.imm = (ii & ~32'h81F) | (32'(w[7]) << 11) | (32'(w[11:8]) << 1); end
            7'h03: begin ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                         d.op = OP_LOAD; d.sb = 1; d.rs1 = w[19:15]; d.rd = w[11:7];
                         d.imm = ii; d.sz = 2'(f3 % 4); d.uns = (f3 >= 4); end
            7'h23: begin ok = (f3 < 3); d.op = OP_STORE; d.sb = 1; d.rs1 = w[19:15];
                         d.rs2 = w[24:20]; d.sz = 2'(f3 % 4);
                         d.imm = (ii & ~32'h1F) | 32'(w[11:7]); end
            7'h13: begin
                       if (f3 == 1) ok = (f7 == 0);
                       if (f3 == 5) ok = (f7 == 0 || f7 == 32);
                       d.op = OP_ALU; d.sb = 1; d.rs1 = w[19:15]; d.rd = w[11:7]; d.imm = ii;
                       d.alu = (f3 == 5 && f7 == 32) ? ALU_SRA : base_alu[f3];
                   end
            7'h33: begin
                       ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                       d.op = OP_ALU; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
                       d.alu = (f7 == 32) ? ((f3 == 0) ? ALU_SUB : ALU_SRA) : base_alu[f3];
                   end
            7'h0F: ok = (f3 == 0);
            7'h73: begin
                       d.imm = ii;
                       if (f3 == 0) begin
                           ok = (w == 32'h73) || (w == 32'h0010_0073);
                           d.op = OP_SYS;
                       end else begin
                           ok = (f3 != 4);
                           d.op = OP_CSR; d.rs1 = w[19:15]; d.rd = w[11:7];
                           d.alu = (f3 % 4 == 1) ? ALU_PASSB : ((f3 % 4 == 2) ? ALU_OR : ALU_AND);
                       end
                   end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d = '0;
            d.addr = a; d.op = OP_NOP; d.alu = ALU_ADD; d.ill = 1; d.imm = w;
        end
        d.we = (d.rd != 0);
        return d;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6F;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7:  w[6:0] = 7'h13;
            8:  w[6:0] = 7'h33;
            9:  begin w[6:0] = 7'h0F; if ($urandom_range(0, 1) == 0) w[14:12] = 3'd0; end
            10: begin
                    w[6:0] = 7'h73;
                    if ($urandom_range(0, 3) == 0) w = 32'h0000_0073;
                    else if ($urandom_range(0, 3) == 0) w = 32'h0010_0073;
                end
            default: ;
        endcase
        if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    function automatic dec_t dut_out();
        dec_t d;
        d.addr = bus.dec_addr_o; d.rs1 = bus.dec_rs1_o; d.rs2 = bus.dec_rs2_o;
        d.rd = bus.dec_rd_o; d.imm = bus.dec_imm_o; d.op = bus.dec_op_o;
        d.alu = bus.dec_alu_o; d.sa = bus.dec_src_a_o; d.sb = bus.dec_src_b_o;
        d.we = bus.dec_we_o; d.sz = bus.dec_mem_size_o; d.uns = bus.dec_mem_uns_o;
        d.ill = bus.dec_illegal_o;
        return d;
    endfunction

    // One clock of stimulus; returns at the following negedge.
    task automatic cycle(input logic rdy, input logic [31:0] w, input logic [31:0] a,
                         input logic dack, input logic fl, input logic ct);
        @(posedge clk);
        #1;
        bus.insn_rdy_i = rdy; bus.insn_i = w; bus.addr_i = a;
        bus.dec_ack_i = dack; flush_r = fl; ct_r = ct;
        @(negedge clk);
        last_acc = rdy && bus.insn_ack_o;
        if (last_acc) exp_q.push_back(model(w, a));
    endtask

    // Monitor: compare on downstream transfer, drop on flush, check stability while held.
    dec_t hold_snap;
    bit   hold_vld = 0;
    always @(negedge clk) begin
        if (!rst_ni) begin
            hold_vld = 0;
        end else if (bus.dec_rdy_o) begin
            if (hold_vld) chk("held_stable", 128'(dut_out()), 128'(hold_snap));
            if (bus.dec_ack_i || flush_r || ct_r) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_entry", 128'(dut_out()), 128'(0));
                end else if (bus.dec_ack_i) begin
                    chk("decode", 128'(dut_out()), 128'(exp_q.pop_front()));
                end else begin
                    void'(exp_q.pop_front());
                end
                hold_vld = 0;
            end else begin
                hold_snap = dut_out();
                hold_vld = 1;
            end
        end else begin
            hold_vld = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] bad [0:2] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_707B};
    logic [31:0] cur_i, cur_a;
    bit          have;

    initial begin
        bus.insn_rdy_i = 0; bus.insn_i = '0; bus.addr_i = '0; bus.dec_ack_i = 0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("rst_dec_rdy", bus.dec_rdy_o, 0);
        chk("rst_op", bus.dec_op_o, OP_NOP);
        chk("rst_imm", bus.dec_imm_o, 0);
        chk("rst_we", bus.dec_we_o, 0);
        chk("rst_rd", bus.dec_rd_o, 0);
        chk("rst_insn_ack", bus.insn_ack_o, 1);

        // ADDI x1, x2, -5
        cycle(1, 32'hFFB1_0093, 32'h100, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        chk("addi_rdy", bus.dec_rdy_o, 1);
        chk("addi_rs1", bus.dec_rs1_o, 2);
        chk("addi_rd", bus.dec_rd_o, 1);
        chk("addi_imm", bus.dec_imm_o, 32'hFFFF_FFFB);
        chk("addi_alu", bus.dec_alu_o, ALU_ADD);
        chk("addi_src_b", bus.dec_src_b_o, 1);
        chk("addi_we", bus.dec_we_o, 1);
        chk("addi_addr", bus.dec_addr_o, 32'h100);

        // BEQ then JAL back-to-back
        cycle(1, 32'hFE00_0EE3, 32'h104, 1, 0, 0);
        cycle(1, 32'h0010_00EF, 32'h108, 1, 0, 0);
        chk("beq_op", bus.dec_op_o, OP_BRANCH);
        chk("beq_imm", bus.dec_imm_o, 32'hFFFF_FFFC);
        chk("beq_we", bus.dec_we_o, 0);
        chk("b2b_ack", bus.insn_ack_o, 1);
        cycle(0, 0, 0, 1, 0, 0);
        chk("jal_op", bus.dec_op_o, OP_JAL);
        chk("jal_imm", bus.dec_imm_o, 32'h0000_0800);

        // Backpressure with two instructions
        cycle(1, 32'h0070_0193, 32'h200, 0, 0, 0);
        cycle(1, 32'h1234_52B7, 32'h204, 0, 0, 0);
        chk("bp_ack_low", bus.insn_ack_o, 0);
        chk("bp_first_imm", bus.dec_imm_o, 7);
        cycle(1, 32'h1234_52B7, 32'h204, 0, 0, 0);
        chk("bp_first_addr", bus.dec_addr_o, 32'h200);
        cycle(1, 32'h1234_52B7, 32'h204, 1, 0, 0);
        chk("bp_accept_on_ack", bus.insn_ack_o, 1);
        cycle(0, 0, 0, 1, 0, 0);
        chk("bp_second_imm", bus.dec_imm_o, 32'h1234_5000);
        chk("bp_second_addr", bus.dec_addr_o, 32'h204);
        cycle(0, 0, 0, 1, 0, 0);
        chk("bp_empty", bus.dec_rdy_o, 0);

        // Illegal words
        cycle(1, bad[0], 32'h300, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(i < 2, (i < 2) ? bad[i + 1] : 32'h0, 32'h304 + 32'(4 * i), 1, 0, 0);
            chk("ill_flag", bus.dec_illegal_o, 1);
            chk("ill_we", bus.dec_we_o, 0);
            chk("ill_raw", bus.dec_imm_o, bad[i]);
        end

        // Control transfer while an entry is held and input is offered
        cycle(1, 32'h0070_0193, 32'h400, 0, 0, 0);
        cycle(1, 32'h1234_52B7, 32'h404, 0, 0, 1);
        chk("ct_ack_blocked", bus.insn_ack_o, 0);
        cycle(1, 32'h1234_52B7, 32'h404, 0, 0, 0);
        chk("ct_dropped", bus.dec_rdy_o, 0);
        // Flush in the same cycle as a downstream transfer: entry still delivered
        cycle(1, 32'h0010_00EF, 32'h408, 1, 1, 0);
        chk("flush_ack_blocked", bus.insn_ack_o, 0);
        chk("flush_entry_presented", bus.dec_addr_o, 32'h404);
        cycle(0, 0, 0, 1, 0, 0);
        chk("flush_empty", bus.dec_rdy_o, 0);

        // Randomized stream
        have = 0;
        repeat (400) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                cur_i = rand_insn();
                cur_a = $urandom & 32'hFFFF_FFFC;
                have = 1;
            end
            cycle(have, cur_i, cur_a, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
            if (last_acc) have = 0;
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_idle", bus.dec_rdy_o, 0);

        // Asynchronous reset mid-stream
        cycle(1, 32'h0070_0193, 32'h500, 0, 0, 0);
        cycle(1, 32'h1234_52B7, 32'h504, 0, 0, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_rdy", bus.dec_rdy_o, 0);
        exp_q.delete();
        bus.insn_rdy_i = 0;
        bus.dec_ack_i = 0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("post_rst_ack", bus.insn_ack_o, 1);
        cycle(1, 32'hFFB1_0093, 32'h600, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        chk("post_rst_rdy", bus.dec_rdy_o, 1);
        chk("post_rst_imm", bus.dec_imm_o, 32'hFFFF_FFFB);
        chk("post_rst_addr", bus.dec_addr_o, 32'h600);
        cycle(0, 0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
